// File: rtl/byte_to_bitstream.sv
// Byte-to-serial converter with a one-byte holding buffer; emits one qualified bit per clock.
// Define BYTE_TO_BITSTREAM_PARITY_EN to append an even-parity bit after every byte.
module byte_to_bitstream #(
  parameter int LSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       data_out,
  output logic       data_out_valid,
  output logic       data_out_first
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

`ifdef BYTE_TO_BITSTREAM_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]    state, state_n;
  logic [DW-1:0] sr, sr_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [DW-1:0] hold_data, hold_data_n;
  logic          buf_full, buf_full_n;
  logic          parity, parity_n;
  logic          out_n, valid_n, first_n;
  logic          accept, free;

  assign data_in_ready = !buf_full;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      sr             <= '0;
      bit_cnt        <= '0;
      hold_data      <= '0;
      buf_full       <= 1'b0;
      parity         <= 1'b0;
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
      data_out_first <= 1'b0;
    end else begin
      state          <= state_n;
      sr             <= sr_n;
      bit_cnt        <= bit_cnt_n;
      hold_data      <= hold_data_n;
      buf_full       <= buf_full_n;
      parity         <= parity_n;
      data_out       <= out_n;
      data_out_valid <= valid_n;
      data_out_first <= first_n;
    end
  end

  // Next-state, load priority and next output values
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    bit_cnt_n   = bit_cnt;
    hold_data_n = hold_data;
    buf_full_n  = buf_full;
    parity_n    = parity;
    out_n       = 1'b0;
    valid_n     = 1'b0;
    first_n     = 1'b0;

    accept = data_in_valid && !buf_full;
    free   = (state == IDLE) || (state == PARITY) ||
             ((state == SHIFT) && (bit_cnt == CW'(7)) && !PARITY_EN);

    if (free) begin
      bit_cnt_n = '0;
      if (buf_full) begin
        sr_n       = hold_data;
        parity_n   = ^hold_data;
        buf_full_n = 1'b0;
        state_n    = SHIFT;
      end else if (accept) begin
        sr_n     = data_in;
        parity_n = ^data_in;
        state_n  = SHIFT;
      end else begin
        state_n = IDLE;
      end
    end else begin
      // Busy shifting; only reaches bit 7 here when the parity slot follows
      if (bit_cnt == CW'(7)) begin
        state_n = PARITY;
      end else begin
        bit_cnt_n = bit_cnt + CW'(1);
        sr_n      = (LSB_FIRST != 0) ? {1'b0, sr[DW-1:1]} : {sr[DW-2:0], 1'b0};
      end
      if (accept) begin
        hold_data_n = data_in;
        buf_full_n  = 1'b1;
      end
    end

    case (state_n)
      SHIFT: begin
        out_n   = (LSB_FIRST != 0) ? sr_n[0] : sr_n[DW-1];
        valid_n = 1'b1;
        first_n = (bit_cnt_n == '0);
      end
      PARITY: begin
        out_n   = parity_n;
        valid_n = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_byte_to_bitstream.sv
// Bench for byte_to_bitstream: MSB-first and LSB-first instances checked against a frame-schedule model.
// Honours BYTE_TO_BITSTREAM_PARITY_EN for the 9-bit frame length.
module tb_byte_to_bitstream;

`ifdef BYTE_TO_BITSTREAM_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       rdy_m, out_m, val_m, first_m;
  logic       rdy_l, out_l, val_l, first_l;

  byte_to_bitstream #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(rdy_m), .data_out(out_m), .data_out_valid(val_m), .data_out_first(first_m)
  );

  byte_to_bitstream #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(rdy_l), .data_out(out_l), .data_out_valid(val_l), .data_out_first(first_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_end = 0;

  // Model: every accepted byte gets an acceptance edge and a start cycle; frames never overlap
  int         q_acc[$];
  int         q_start[$];
  logic [7:0] q_byte[$];

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_ready(input int t);
    foreach (q_acc[i])
      if (q_acc[i] <= t && t < q_start[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic expect_out(input int t, input bit lsb, output logic o, output logic v, output logic f);
    logic [7:0] b;
    int k;
    o = 1'b0; v = 1'b0; f = 1'b0;
    foreach (q_start[i]) begin
      k = t - q_start[i];
      if (k >= 0 && k < FL) begin
        b = q_byte[i];
        v = 1'b1;
        f = (k == 0);
        if (k < 8) o = lsb ? b[k] : b[7-k];
        else       o = ^b;
      end
    end
  endtask

  // One clock: drive inputs, check this cycle at the falling edge, advance the model at the rising edge
  task automatic step(input logic v, input logic [7:0] d, input logic r, output bit acc);
    logic eo, ev, ef, er;
    int s;
    data_in_valid = v;
    data_in       = d;
    rst           = r;
    @(negedge clk);
    er = exp_ready(cyc);
    expect_out(cyc, 1'b0, eo, ev, ef);
    check("msb_data", out_m, eo);
    check("msb_valid", val_m, ev);
    check("msb_first", first_m, ef);
    check("msb_ready", rdy_m, er);
    expect_out(cyc, 1'b1, eo, ev, ef);
    check("lsb_data", out_l, eo);
    check("lsb_valid", val_l, ev);
    check("lsb_first", first_l, ef);
    check("lsb_ready", rdy_l, er);
    acc = v && r && er;
    @(posedge clk);
    cyc++;
    if (!r) begin
      q_acc.delete(); q_start.delete(); q_byte.delete();
      last_end = cyc;
    end else if (acc) begin
      s = (cyc > last_end + 1) ? cyc : last_end + 1;
      q_acc.push_back(cyc);
      q_start.push_back(s);
      q_byte.push_back(d);
      last_end = s + FL - 1;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      step(1'b1, d, 1'b1, acc);
      n++;
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $error("FAIL send_timeout: byte %h not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    rst = 1'b0;
    data_in_valid = 1'b0;
    data_in = 8'h00;
    @(posedge clk);
    #1;
    cyc = 0;
    last_end = 0;
    // Reset state
    step(1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    idle(2);
    // Single byte
    send(8'hA5);
    idle(FL + 4);
    // Back-to-back with valid held high
    send(8'h81);
    send(8'h42);
    idle(2 * FL + 4);
    // Producer gap
    send(8'hFF);
    idle(FL + 2);
    send(8'h00);
    idle(FL + 3);
    // Reset on the 4th bit of 0xF0 while 0x0F is buffered
    send(8'hF0);
    send(8'h0F);
    idle(2);
    step(1'b0, 8'h00, 1'b0, acc);
    idle(2 * FL + 4);
    // Parity-sensitive bytes
    send(8'h07);
    send(8'h01);
    idle(2 * FL + 2);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 80) != 0, acc);
    end
    idle(2 * FL + 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_to_bitstream.md
# byte_to_bitstream

Byte-to-serial converter: accepts 8-bit bytes on a valid/ready handshake and emits them one bit per clock as a qualified bitstream. It is the transmit-side counterpart of `bitstream_to_byte` and feeds the modulator/channel path. A one-byte holding buffer lets back-to-back bytes stream with no idle bit slots between them.

## Interface
- `LSB_FIRST`, default 0: 0 sends bit 7 first; 1 sends bit 0 first.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-low reset: 0 resets on the next rising `clk` edge.
- `data_in`  input  8  byte to serialize.
- `data_in_valid`  input  1  `data_in` is presented.
- `data_in_ready`  output  1  block can take a byte this cycle. It is `!buf_full`, combinational from state only.
- `data_out`  output  1  current serial bit. It is 0 whenever `data_out_valid` is 0.
- `data_out_valid`  output  1  `data_out` carries a real bit this cycle.
- `data_out_first`  output  1  high with `data_out_valid` on the first bit of each byte. Used for receiver alignment.

## Operation
- **Storage:**
  - 8-bit shift register with a 3-bit bit counter (`bit_cnt`).
  - 1-entry holding buffer with a `buf_full` flag.
- **State machine:** IDLE, SHIFT (and PARITY when the parity option is compiled in).
- **Handshake:** a byte is accepted on any edge where `data_in_valid && data_in_ready`. A byte presented while `data_in_ready` is 0 is not taken; the producer holds it.
- **Shifter free at an edge:** the shifter counts as free when the state is IDLE, or when the state is SHIFT with `bit_cnt==7` and no parity option.
- **Load priority when the shifter is free:**
  - If the buffer is full, the buffer loads the shifter and the buffer empties.
  - Otherwise, if a byte is accepted at that edge, it loads the shifter directly and the buffer stays empty.
  - Otherwise, the state goes to IDLE.
- **Shifter busy and a byte is accepted:** the byte goes into the buffer and `buf_full` is set.
- **Buffer full at an edge where the shifter is free:** the buffer moves into the shifter and `data_in_ready` returns to 1 on the next cycle. No byte can be accepted at that edge, because `data_in_ready` was 0.
- **SHIFT:**
  - `data_out` = sr[7] (or sr[0] if `LSB_FIRST`).
  - `bit_cnt` increments every cycle and wraps from 7 to 0 on a reload.
  - `data_out_first` = (`bit_cnt`==0).
- **Reset:**
  - Aborts any byte in flight and discards the buffer contents.
  - The state goes to IDLE and `bit_cnt` goes to 0.
  - `data_out`, `data_out_valid` and `data_out_first` are 0.
  - `data_in_ready` is 1 once reset is released. It is 1 during reset because the buffer is empty.

## Timing
- **Latency:** a byte accepted at edge E into an idle block drives its first bit on the cycle after E. The 8 bits occupy cycles E+1..E+8.
- **Throughput:** with the buffer kept full, `data_out_valid` stays high continuously, one byte every 8 cycles with no gaps.
- **Buffer fill with no bubble:** a producer holding `data_in_valid` high fills the buffer on the edge after the first byte's load. `data_in_ready` then drops to 0 until that byte enters the shifter.
- **Producer gap:** when the buffer is empty at the last-bit edge, `data_out_valid` drops the next cycle. Any later acceptance restarts with 1-cycle latency.
- **Outputs are registered:** `data_out`, `data_out_valid` and `data_out_first` are all registered.

## Configuration
- **`BYTE_TO_BITSTREAM_PARITY_EN` defined:**
  - After bit 7 of every byte, one extra cycle in state PARITY outputs even parity (XOR of the 8 data bits), with `data_out_valid`=1 and `data_out_first`=0.
  - The shifter is free only on the PARITY edge.
  - Each byte takes 9 cycles; throughput is 1 byte per 9 cycles.
- **Not defined:**
  - No PARITY state exists.
  - Frames are 8 bits, exactly as described above.

## Test plan
- **Single byte:** after reset, send 0xA5 with `LSB_FIRST`=0.
  - `data_out` = 1,0,1,0,0,1,0,1 on the 8 cycles after acceptance.
  - `data_out_first`=1 on the first bit only.
  - `data_out_valid` then returns to 0.
- **Back-to-back:** 0x81 then 0x42 with `data_in_valid` held high.
  - 16 contiguous valid bits: 10000001 01000010.
  - `data_in_ready` is 0 while the buffer holds 0x42 and returns to 1 the cycle after 0x42 loads.
- **Producer gap:** send 0xFF, idle 3 cycles, then send 0x00.
  - 8 valid 1s, then 3 cycles with `data_out_valid`=0, then 8 valid 0s.
- **Reset mid-byte:** assert `rst`=0 on the 4th bit of 0xF0 while 0x0F sits in the buffer.
  - The next cycle has all outputs 0 and `data_in_ready`=1.
  - Neither byte's remaining bits ever appear.
- **LSB-first:** with `LSB_FIRST`=1, byte 0x01 produces bits 1,0,0,0,0,0,0,0.
- **Parity build:** with `BYTE_TO_BITSTREAM_PARITY_EN` defined.
  - 0xA5 produces a 9th bit of 0.
  - 0x07 produces a 9th bit of 1.
  - Back-to-back bytes are spaced exactly 9 cycles apart.
